// File: rtl/cpu_pkg.sv
// cpu_pkg: shared datapath types and constants for the register file and
// the later pipeline stages that reuse the writeback entry.
//   REG_COUNT / REG_ADDR_W : architectural register count and index width
//   DATA_W                 : default datapath width
//   reg_addr_t, word_t     : register index and data word types
//   wb_entry_t             : one pending writeback {valid, addr, data}
package cpu_pkg;

  localparam int REG_COUNT  = 32;
  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0]     word_t;

  typedef struct packed {
    logic      valid;
    reg_addr_t addr;
    word_t     data;
  } wb_entry_t;

endpackage

// File: rtl/rb_wb_stage.sv
// rb_wb_stage: one-entry writeback staging register with the R0 filter.
// A write request is captured on the rising clock edge and presented to the
// array for commit on the following edge.
// Ports:
//   i_clk, i_rst          : clock, asynchronous active-high reset
//   i_we, i_wa, i_wd      : incoming write request
//   o_valid, o_addr, o_data : staged write (addr/data are 0 when not valid)
module rb_wb_stage
  import cpu_pkg::*;
#(
  parameter int WIDTH    = DATA_W,
  parameter int ZERO_REG = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_we,
  input  reg_addr_t        i_wa,
  input  logic [WIDTH-1:0] i_wd,
  output logic             o_valid,
  output reg_addr_t        o_addr,
  output logic [WIDTH-1:0] o_data
);

  logic             r_valid;
  reg_addr_t        r_addr;
  logic [WIDTH-1:0] r_data;
  logic             w_accept;

  // Writes to a hardwired-zero R0 are dropped here so they never show as
  // pending and never reach the commit counter.
  assign w_accept = i_we && !((ZERO_REG != 0) && (i_wa == '0));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_valid <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
    end else if (w_accept) begin
      r_valid <= 1'b1;
      r_addr  <= i_wa;
      r_data  <= i_wd;
    end else begin
      r_valid <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
    end
  end

  assign o_valid = r_valid;
  assign o_addr  = r_addr;
  assign o_data  = r_data;

endmodule

// File: rtl/reg_bank32.sv
// reg_bank32: 32 x WIDTH architectural register file, one staged write port,
// all registers driven in parallel toward the read-port multiplexers.
// Ports:
//   CLK, RST        : clock (rising edge), asynchronous active-high reset
//   WE, WA, WD      : write request, captured into the staging register
//   PEND, PEND_A    : staging register holds a write / its destination
//   WCOUNT          : committed write count, wraps at 16'hFFFF -> 0
//   Q00..Q31        : register contents
// Build option:
//   RF_WRITE_FORWARD_EN : when defined, the staged data is shown on Q[PEND_A]
//                         before it commits (one-edge write-to-read latency).
//                         Undefined (default): Qxx come straight from flops.
module reg_bank32
  import cpu_pkg::*;
#(
  parameter int WIDTH    = DATA_W,
  parameter int ZERO_REG = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             WE,
  input  reg_addr_t        WA,
  input  logic [WIDTH-1:0] WD,
  output logic             PEND,
  output reg_addr_t        PEND_A,
  output logic [15:0]      WCOUNT,
  output logic [WIDTH-1:0] Q00, Q01, Q02, Q03, Q04, Q05, Q06, Q07,
  output logic [WIDTH-1:0] Q08, Q09, Q10, Q11, Q12, Q13, Q14, Q15,
  output logic [WIDTH-1:0] Q16, Q17, Q18, Q19, Q20, Q21, Q22, Q23,
  output logic [WIDTH-1:0] Q24, Q25, Q26, Q27, Q28, Q29, Q30, Q31
);

  logic             w_stg_valid;
  reg_addr_t        w_stg_addr;
  logic [WIDTH-1:0] w_stg_data;

  logic [WIDTH-1:0] r_regs [REG_COUNT];
  logic [15:0]      r_wcount;
  logic [WIDTH-1:0] w_q    [REG_COUNT];

  rb_wb_stage #(
    .WIDTH    (WIDTH),
    .ZERO_REG (ZERO_REG)
  ) u_wb_stage (
    .i_clk   (CLK),
    .i_rst   (RST),
    .i_we    (WE),
    .i_wa    (WA),
    .i_wd    (WD),
    .o_valid (w_stg_valid),
    .o_addr  (w_stg_addr),
    .o_data  (w_stg_data)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < REG_COUNT; i++) r_regs[i] <= '0;
      r_wcount <= '0;
    end else if (w_stg_valid) begin
      r_regs[w_stg_addr] <= w_stg_data;
      r_wcount           <= r_wcount + 16'd1;
    end
  end

  for (genvar g = 0; g < REG_COUNT; g++) begin : g_rd
    if ((ZERO_REG != 0) && (g == 0)) begin : g_zero
      assign w_q[g] = '0;
    end else begin : g_reg
`ifdef RF_WRITE_FORWARD_EN
      assign w_q[g] = (w_stg_valid && (w_stg_addr == reg_addr_t'(g))) ? w_stg_data : r_regs[g];
`else
      assign w_q[g] = r_regs[g];
`endif
    end
  end

  assign PEND   = w_stg_valid;
  assign PEND_A = w_stg_addr;   // staging addr is already 0 when not valid
  assign WCOUNT = r_wcount;

  assign Q00 = w_q[0];   assign Q01 = w_q[1];   assign Q02 = w_q[2];   assign Q03 = w_q[3];
  assign Q04 = w_q[4];   assign Q05 = w_q[5];   assign Q06 = w_q[6];   assign Q07 = w_q[7];
  assign Q08 = w_q[8];   assign Q09 = w_q[9];   assign Q10 = w_q[10];  assign Q11 = w_q[11];
  assign Q12 = w_q[12];  assign Q13 = w_q[13];  assign Q14 = w_q[14];  assign Q15 = w_q[15];
  assign Q16 = w_q[16];  assign Q17 = w_q[17];  assign Q18 = w_q[18];  assign Q19 = w_q[19];
  assign Q20 = w_q[20];  assign Q21 = w_q[21];  assign Q22 = w_q[22];  assign Q23 = w_q[23];
  assign Q24 = w_q[24];  assign Q25 = w_q[25];  assign Q26 = w_q[26];  assign Q27 = w_q[27];
  assign Q28 = w_q[28];  assign Q29 = w_q[29];  assign Q30 = w_q[30];  assign Q31 = w_q[31];

endmodule

// File: tb/tb_reg_bank32.sv
module tb_reg_bank32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        we  = 1'b0;
  logic [4:0]  wa  = '0;
  logic [31:0] wd  = '0;
  logic        pend;
  logic [4:0]  pend_a;
  logic [15:0] wcount;
  wire  [31:0] q [32];

  int checks   = 0;
  int failures = 0;
  int nprint   = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  reg_bank32 dut (
    .CLK(clk), .RST(rst), .WE(we), .WA(wa), .WD(wd),
    .PEND(pend), .PEND_A(pend_a), .WCOUNT(wcount),
    .Q00(q[0]),   .Q01(q[1]),   .Q02(q[2]),   .Q03(q[3]),
    .Q04(q[4]),   .Q05(q[5]),   .Q06(q[6]),   .Q07(q[7]),
    .Q08(q[8]),   .Q09(q[9]),   .Q10(q[10]),  .Q11(q[11]),
    .Q12(q[12]),  .Q13(q[13]),  .Q14(q[14]),  .Q15(q[15]),
    .Q16(q[16]),  .Q17(q[17]),  .Q18(q[18]),  .Q19(q[19]),
    .Q20(q[20]),  .Q21(q[21]),  .Q22(q[22]),  .Q23(q[23]),
    .Q24(q[24]),  .Q25(q[25]),  .Q26(q[26]),  .Q27(q[27]),
    .Q28(q[28]),  .Q29(q[29]),  .Q30(q[30]),  .Q31(q[31])
  );

  // Reference: a write sampled at one edge lands in the array at the next
  // edge; R0 writes vanish; the count of landed writes is kept modulo 2^16.
  logic [31:0] m_regs [32];
  bit          m_pv;
  int          m_pa;
  logic [31:0] m_pd;
  int unsigned m_cnt;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
      m_pv = 0; m_pa = 0; m_pd = 32'd0; m_cnt = 0;
    end else begin
      if (m_pv) begin
        m_regs[m_pa] = m_pd;
        m_cnt = (m_cnt + 1) % 65536;
      end
      if (we === 1'b1 && wa != 5'd0) begin
        m_pv = 1; m_pa = int'(wa); m_pd = wd;
      end else begin
        m_pv = 0; m_pa = 0; m_pd = 32'd0;
      end
    end
  end

  function automatic logic [31:0] exp_q(input int i);
    logic [31:0] e;
    e = m_regs[i];
`ifdef RF_WRITE_FORWARD_EN
    if (m_pv && m_pa == i) e = m_pd;
`endif
    if (i == 0) e = 32'd0;
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst && chk_en) begin
      bit bad;
      bad = 0;
      checks++;
      for (int i = 0; i < 32; i++) begin
        if (q[i] !== exp_q(i)) begin
          bad = 1;
          if (nprint < 20) begin
            nprint++;
            $display("FAIL model_q%0d got=%h exp=%h t=%0t", i, q[i], exp_q(i), $time);
          end
        end
      end
      if (pend !== m_pv || pend_a !== 5'(m_pa) || wcount !== 16'(m_cnt)) begin
        bad = 1;
        if (nprint < 20) begin
          nprint++;
          $display("FAIL model_ctl got pend=%b a=%0d cnt=%0d exp pend=%b a=%0d cnt=%0d t=%0t",
                   pend, pend_a, wcount, m_pv, m_pa, m_cnt, $time);
        end
      end
      if (bad) failures++;
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Entered at a falling edge; inputs change 1ns later, one rising edge passes,
  // and the task returns at the next falling edge.
  task automatic cyc(input bit w, input logic [4:0] a, input logic [31:0] d);
    #1;
    we = w; wa = a; wd = d;
    @(negedge clk);
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    #1 rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk); @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_wcount", 32'(wcount), 32'd0);
    chk("reset_pend",   32'(pend),   32'd0);
    chk_en = 1'b1;

    // Basic write
    cyc(1, 5'd7, 32'h12345678);
    chk("basic_pend",   32'(pend),   32'd1);
    chk("basic_pend_a", 32'(pend_a), 32'd7);
    cyc(0, 5'd0, 32'd0);
    chk("basic_q07",    q[7],        32'h12345678);
    chk("basic_wcount", 32'(wcount), 32'd1);
    chk("basic_pend0",  32'(pend),   32'd0);

    // Back-to-back, same index then another
    cyc(1, 5'd3, 32'd1);
    cyc(1, 5'd3, 32'd2);
    chk("b2b_q03_first", q[3], 32'd1);
    cyc(1, 5'd4, 32'd3);
    chk("b2b_q03_second", q[3], 32'd2);
    cyc(0, 5'd0, 32'd0);
    chk("b2b_q04",    q[4],        32'd3);
    chk("b2b_wcount", 32'(wcount), 32'd4);

    // R0 filter
    cyc(1, 5'd0, 32'hFFFFFFFF);
    chk("r0_pend", 32'(pend), 32'd0);
    cyc(0, 5'd0, 32'd0);
    chk("r0_q00",    q[0],        32'd0);
    chk("r0_wcount", 32'(wcount), 32'd4);

    // Forwarding visibility after the first edge
    cyc(1, 5'd9, 32'hA5A5A5A5);
`ifdef RF_WRITE_FORWARD_EN
    chk("fwd_q09_edge1", q[9], 32'hA5A5A5A5);
`else
    chk("nofwd_q09_edge1", q[9], 32'd0);
`endif
    cyc(0, 5'd0, 32'd0);
    chk("q09_edge2", q[9], 32'hA5A5A5A5);

    // Randomized traffic checked every cycle by the model
    for (int n = 0; n < 400; n++)
      cyc(($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)), $urandom);
    cyc(0, 5'bxxxxx, 32'd0);
    cyc(0, 5'd0, 32'd0);

    // Asynchronous reset with a pending write to R5
    cyc(0, 5'd5, 32'h55);
    cyc(0, 5'd0, 32'd0);
    cyc(1, 5'd5, 32'hDEADBEEF);
    chk("rst_pre_pend", 32'(pend), 32'd1);
    #2 rst = 1'b1;
    #1;
    begin
      logic [31:0] orq;
      orq = 32'd0;
      for (int i = 0; i < 32; i++) orq |= q[i];
      chk("rst_async_q_or", orq, 32'd0);
    end
    chk("rst_async_pend",   32'(pend),   32'd0);
    chk("rst_async_wcount", 32'(wcount), 32'd0);
    we = 1'b0;
    #1 rst = 1'b0;
    @(negedge clk);
    cyc(0, 5'd0, 32'd0);
    cyc(0, 5'd0, 32'd0);
    chk("rst_q05_stays0", q[5], 32'd0);

    // Count wrap: 65535 writes to R1 then one more
    for (int n = 0; n < 65535; n++) cyc(1, 5'd1, 32'(n));
    cyc(1, 5'd1, 32'hC0FFEE01);
    chk("wrap_prev_count", 32'(wcount), 32'd65535);
    cyc(0, 5'd0, 32'd0);
    chk("wrap_wcount", 32'(wcount), 32'd0);
    chk("wrap_q01",    q[1],        32'hC0FFEE01);
    cyc(0, 5'd0, 32'd0);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_bank32.md
Name: reg_bank32

Overview:
- Architectural register storage for the CPU datapath: 32 registers of WIDTH bits, one write port.
- Sits directly upstream of the 32-to-1 read-port multiplexers. All 32 register values are driven in parallel on Q00..Q31, which connect straight to the mux I00..I31 inputs.
- Writes pass through a one-entry writeback staging register before they commit to the array, so write timing is decoupled from the ALU/memory stage.

Parameters:
- WIDTH, 32, data width of each register and of WD/Qxx.
- ZERO_REG, 1, when 1 register 0 is hardwired to zero and writes to it are discarded; when 0 it is an ordinary register.

Ports:
- CLK  input  1  system clock, rising-edge active.
- RST  input  1  asynchronous, active-high reset.
- WE  input  1  write request, sampled on rising CLK.
- WA  input  5  write destination register index.
- WD  input  WIDTH  write data.
- PEND  output  1  staging register holds an uncommitted write.
- PEND_A  output  5  destination index of the staged write; 0 when PEND=0.
- WCOUNT  output  16  count of committed writes, wraps at 16'hFFFF -> 0.
- Q00..Q31  output  WIDTH each  current register contents, one port per register.

Behaviour:
- Clock and reset (already decided): one clock CLK; RST is asynchronous and active-high. Asserting RST immediately clears, without waiting for a clock edge:
  - all 32 registers to 0;
  - the staging register (valid=0, addr=0, data=0);
  - PEND=0, PEND_A=0, WCOUNT=0.
- Reset mid-operation: a staged write that has not committed is lost and is never written to the array.
- Pipeline: two stages, capture then commit.
- Capture (edge N):
  - If WE=1 and not (ZERO_REG=1 and WA=0), the staging register loads valid=1, addr=WA, data=WD.
  - Otherwise the staging register loads valid=0, addr=0.
- Commit (edge N+1): if the staging register was valid at edge N+1, reg[addr] <= data and WCOUNT increments.
- Commit and capture happen on the same edge. Back-to-back writes every cycle therefore sustain full throughput with no stalls.
- Same-index writes on consecutive cycles commit in order; the last write wins.
- Visibility without forwarding: the new value appears on Qxx after the second rising edge following the WE sample.
- PEND and PEND_A reflect the staging register directly (registered outputs, no combinational path from WE).
- Register 0 with ZERO_REG=1: Q00 is constant 0 at all times. A write to R0 never sets PEND and never increments WCOUNT.
- Qxx outputs are registered values, except for the forwarding path described under Optional Feature.
- WCOUNT wrap: a commit at WCOUNT=16'hFFFF yields 0; no flag is raised.
- X/undefined WA while WE=0 has no effect.

Optional Feature:
- Macro: RF_WRITE_FORWARD_EN.
- Defined:
  - While the staging register is valid, Q[PEND_A] combinationally shows the staged data instead of the array value. All other Qxx are unchanged.
  - Effective write-to-read latency is one edge.
  - The Q00 zero rule still takes priority.
- Undefined: no forwarding mux. Qxx come straight from the array flops, and latency is two edges.

Decomposition:
- Shared package (cpu_pkg):
  - REG_COUNT=32 and REG_ADDR_W=5 constants;
  - DATA_W=32 default;
  - typedef reg_addr_t (5 bits) and word_t (DATA_W bits);
  - a writeback-entry struct {valid, addr, data}, reused by later pipeline stages.
- One natural sub-module, rb_wb_stage: the staging register together with the R0-filter logic.
- The 32-entry array, the decode and WCOUNT stay in reg_bank32.

Test Plan:
- Reset: assert RST mid-cycle with a staged write pending (WA=5, WD=32'hDEADBEEF) -> immediately all Qxx=0, PEND=0, WCOUNT=0; after release, Q05 stays 0.
- Basic write: WE=1, WA=7, WD=32'h12345678 for one cycle -> PEND=1 and PEND_A=7 after edge 1; Q07=32'h12345678 and WCOUNT=1 after edge 2; PEND=0.
- Back-to-back writes: WA=3/WD=1, then WA=3/WD=2, then WA=4/WD=3 on consecutive cycles -> Q03 goes 1 then 2, Q04=3, WCOUNT=3, no stall cycles.
- R0 filter (ZERO_REG=1): WE=1, WA=0, WD=32'hFFFFFFFF -> PEND never asserts, Q00=0, WCOUNT unchanged.
- Forwarding (RF_WRITE_FORWARD_EN defined): WE=1, WA=9, WD=32'hA5A5A5A5 -> Q09=32'hA5A5A5A5 right after edge 1, while the array has not yet committed. With the macro undefined, the value appears only after edge 2.
- WCOUNT wrap: preload the count by issuing 65535 writes to R1, then one more write -> WCOUNT=0 and Q01 holds the last WD.
